slc3_mem_responder: RTL and testbench

- Memory and memory-mapped I/O responder on the SLC-3 CPU data bus; it is the target side of every CPU load and store.
- Each access uses a request/ready handshake with a fixed, parameterised number of wait states, emulating off-chip SRAM latency.
- Contains an on-chip word memory and one I/O location at x0FFFF: reads return the board switches, writes update the hex display register.
- Instantiated by the SLC-3 top level between the CPU's MAR/MDR path and the board switches/HEX drivers.

---
 rtl/slc3_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_slc3_mem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/slc3_mem_responder.sv
// SLC-3 data-bus target: on-chip word memory plus one memory-mapped I/O word (switches/hex),
// answering each request after a fixed number of wait states with a one-cycle Ready pulse.
module slc3_mem_responder #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_in,
  input  logic [DATA_W-1:0] Switches,
  output logic [DATA_W-1:0] Data_out,
  output logic              Ready,
  output logic              Busy,
  output logic              Err,
  output logic [DATA_W-1:0] Hex_out
);

  localparam int                MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] IO_ADDR = ADDR_W'('h0FFFF);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [3:0]        WS      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   hex_q, hex_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                sel_mem_q, sel_mem_d;

  logic                enter_done;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_we;
  logic [DATA_W-1:0]   acc_data;
  logic                is_io;
  logic                in_range;
  logic                mem_we;
  logic                mem_re;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   mem_rd_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    data_d     = data_q;
    busy_d     = busy_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    hex_d      = hex_q;
    rd_d       = rd_q;
    sel_mem_d  = sel_mem_q;
    enter_done = 1'b0;
    acc_addr   = addr_q;
    acc_we     = we_q;
    acc_data   = data_q;

    case (state_q)
      S_IDLE: begin
        if (Req) begin
          addr_d = ADDR;
          we_d   = WE;
          data_d = Data_in;
          busy_d = 1'b1;
          if (WAIT_STATES == 0) begin
            // Zero-wait access completes off the live bus values at the acceptance edge
            state_d    = S_DONE;
            enter_done = 1'b1;
            acc_addr   = ADDR;
            acc_we     = WE;
            acc_data   = Data_in;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = S_DONE;
          cnt_d      = 4'd0;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    is_io    = (acc_addr == IO_ADDR);
    in_range = !is_io && (acc_addr < DEPTH_A);

    // The access itself commits on the edge entering DONE so results are visible with Ready
    if (enter_done) begin
      ready_d = 1'b1;
      err_d   = !is_io && !in_range;
      if (!acc_we) begin
        sel_mem_d = in_range;
        if (is_io) begin
          rd_d = Switches;
        end else if (!in_range) begin
          rd_d = '0;
        end
      end else if (is_io) begin
        hex_d = acc_data;
      end
    end
  end

  assign mem_we = enter_done && acc_we && in_range && !Reset;
  assign mem_re = enter_done && !acc_we && in_range;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      hex_q     <= '0;
      rd_q      <= '0;
      sel_mem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      hex_q     <= hex_d;
      rd_q      <= rd_d;
      sel_mem_q <= sel_mem_d;
    end
  end

  // Unreset array with a registered read port so it maps onto block RAM
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[acc_addr[MEM_AW-1:0]] <= acc_data;
    end
    if (mem_re) begin
      mem_rd_q <= mem[acc_addr[MEM_AW-1:0]];
    end
  end

  assign Data_out = sel_mem_q ? mem_rd_q : rd_q;
  assign Ready    = ready_q;
  assign Busy     = busy_q;
  assign Err      = err_q;
  assign Hex_out  = hex_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder (defaults: DEPTH=256, WAIT_STATES=2).
module tb_slc3_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic        WE;
  logic [19:0] ADDR;
  logic [15:0] Data_in;
  logic [15:0] Switches;
  logic [15:0] Data_out;
  logic        Ready;
  logic        Busy;
  logic        Err;
  logic [15:0] Hex_out;

  int vectors = 0;
  int miscompares = 0;

  slc3_mem_responder #(
    .ADDR_W(20), .DATA_W(16), .DEPTH(256), .WAIT_STATES(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .WE(WE), .ADDR(ADDR),
    .Data_in(Data_in), .Switches(Switches), .Data_out(Data_out),
    .Ready(Ready), .Busy(Busy), .Err(Err), .Hex_out(Hex_out)
  );

  always #5 Clk = ~Clk;

  // Presents a one-cycle request; returns 1ns after the acceptance edge (cycle 1)
  task automatic issue(input logic we, input logic [19:0] a, input logic [15:0] d);
    Req = 1'b1; WE = we; ADDR = a; Data_in = d;
    @(posedge Clk); #1;
    Req = 1'b0; WE = 1'b0; ADDR = 20'h0; Data_in = 16'h0;
    $display("access we=%0b addr=%05h data=%04h", we, a, d);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = 1'b0; WE = 1'b0; ADDR = '0; Data_in = '0; Switches = '0;
    repeat (2) @(posedge Clk);
    #1;
    vectors += 5;
    if (Data_out !== 16'h0000) begin miscompares++; $display("FAIL reset_data_out got %h expected 0000", Data_out); end
    if (Ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b expected 0", Ready); end
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", Busy); end
    if (Err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b expected 0", Err); end
    if (Hex_out !== 16'h0000) begin miscompares++; $display("FAIL reset_hex got %h expected 0000", Hex_out); end
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_mem_write();
    issue(1'b1, 20'h00010, 16'h3A5C);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin @(posedge Clk); #1; end
      vectors += 4;
      if (Busy !== (c <= 3)) begin miscompares++; $display("FAIL wr_busy c%0d got %b expected %b", c, Busy, c <= 3); end
      if (Ready !== (c == 3)) begin miscompares++; $display("FAIL wr_ready c%0d got %b expected %b", c, Ready, c == 3); end
      if (Data_out !== 16'h0000) begin miscompares++; $display("FAIL wr_data_out c%0d got %h expected 0000", c, Data_out); end
      if (Err !== 1'b0) begin miscompares++; $display("FAIL wr_err c%0d got %b expected 0", c, Err); end
    end
  endtask

  task automatic test_mem_read();
    logic [15:0] exp_d;
    issue(1'b0, 20'h00010, 16'h0);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin @(posedge Clk); #1; end
      exp_d = (c >= 3) ? 16'h3A5C : 16'h0000;
      vectors += 4;
      if (Busy !== (c <= 3)) begin miscompares++; $display("FAIL rd_busy c%0d got %b expected %b", c, Busy, c <= 3); end
      if (Ready !== (c == 3)) begin miscompares++; $display("FAIL rd_ready c%0d got %b expected %b", c, Ready, c == 3); end
      if (Data_out !== exp_d) begin miscompares++; $display("FAIL rd_data_out c%0d got %h expected %h", c, Data_out, exp_d); end
      if (Err !== 1'b0) begin miscompares++; $display("FAIL rd_err c%0d got %b expected 0", c, Err); end
    end
  endtask

  task automatic test_io();
    Switches = 16'hBEEF;
    issue(1'b0, 20'h0FFFF, 16'h0);
    repeat (2) @(posedge Clk);
    #1;
    vectors += 3;
    if (Ready !== 1'b1) begin miscompares++; $display("FAIL io_rd_ready got %b expected 1", Ready); end
    if (Data_out !== 16'hBEEF) begin miscompares++; $display("FAIL io_rd_data got %h expected beef", Data_out); end
    if (Err !== 1'b0) begin miscompares++; $display("FAIL io_rd_err got %b expected 0", Err); end
    Switches = 16'h1111;
    @(posedge Clk); #1;
    vectors++;
    if (Data_out !== 16'hBEEF) begin miscompares++; $display("FAIL io_rd_hold got %h expected beef", Data_out); end
    issue(1'b1, 20'h0FFFF, 16'h1234);
    @(posedge Clk); #1;
    vectors++;
    if (Hex_out !== 16'h0000) begin miscompares++; $display("FAIL io_hex_early got %h expected 0000", Hex_out); end
    @(posedge Clk); #1;
    vectors += 3;
    if (Ready !== 1'b1) begin miscompares++; $display("FAIL io_wr_ready got %b expected 1", Ready); end
    if (Hex_out !== 16'h1234) begin miscompares++; $display("FAIL io_hex got %h expected 1234", Hex_out); end
    if (Data_out !== 16'hBEEF) begin miscompares++; $display("FAIL io_wr_data_out got %h expected beef", Data_out); end
    @(posedge Clk); #1;
  endtask

  task automatic test_out_of_range();
    issue(1'b0, 20'h00200, 16'h0);
    repeat (2) @(posedge Clk);
    #1;
    vectors += 3;
    if (Ready !== 1'b1) begin miscompares++; $display("FAIL oor_rd_ready got %b expected 1", Ready); end
    if (Err !== 1'b1) begin miscompares++; $display("FAIL oor_rd_err got %b expected 1", Err); end
    if (Data_out !== 16'h0000) begin miscompares++; $display("FAIL oor_rd_data got %h expected 0000", Data_out); end
    @(posedge Clk); #1;
    vectors++;
    if (Err !== 1'b0) begin miscompares++; $display("FAIL oor_err_pulse got %b expected 0", Err); end
    issue(1'b1, 20'h00300, 16'h5555);
    repeat (2) @(posedge Clk);
    #1;
    vectors += 4;
    if (Ready !== 1'b1) begin miscompares++; $display("FAIL oor_wr_ready got %b expected 1", Ready); end
    if (Err !== 1'b1) begin miscompares++; $display("FAIL oor_wr_err got %b expected 1", Err); end
    if (Data_out !== 16'h0000) begin miscompares++; $display("FAIL oor_wr_data_out got %h expected 0000", Data_out); end
    if (Hex_out !== 16'h1234) begin miscompares++; $display("FAIL oor_wr_hex got %h expected 1234", Hex_out); end
    @(posedge Clk); #1;
    // x00110 aliases word x10 if the address were truncated
    issue(1'b1, 20'h00110, 16'h5555);
    repeat (3) @(posedge Clk);
    #1;
    issue(1'b0, 20'h00010, 16'h0);
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if (Data_out !== 16'h3A5C) begin miscompares++; $display("FAIL oor_no_alias got %h expected 3a5c", Data_out); end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d;
    for (int i = 0; i < 12; i++) begin
      issue(1'b1, 20'(i), 16'h1000 + 16'(i));
      repeat (3) @(posedge Clk);
      #1;
    end
    Req = 1'b1; WE = 1'b0;
    for (int t = 0; t < 12; t++) begin
      ADDR = 20'(t);
      @(posedge Clk); #1;
      vectors += 2;
      if (Ready !== ((t % 4) == 2)) begin miscompares++; $display("FAIL b2b_ready t%0d got %b expected %b", t, Ready, (t % 4) == 2); end
      if (Busy !== ((t % 4) != 3)) begin miscompares++; $display("FAIL b2b_busy t%0d got %b expected %b", t, Busy, (t % 4) != 3); end
      if ((t % 4) == 2) begin
        exp_d = 16'h1000 + 16'(t - 2);
        vectors++;
        if (Data_out !== exp_d) begin miscompares++; $display("FAIL b2b_data t%0d got %h expected %h", t, Data_out, exp_d); end
        $display("access we=0 addr=%05h data=%04h (held Req)", 20'(t - 2), Data_out);
      end
    end
    Req = 1'b0; ADDR = '0;
    @(posedge Clk); #1;
  endtask

  task automatic test_abort();
    issue(1'b1, 20'h00020, 16'h0ABC);
    repeat (3) @(posedge Clk);
    #1;
    issue(1'b1, 20'h00020, 16'h7777);
    Reset = 1'b1;
    #1;
    vectors += 4;
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b expected 0", Busy); end
    if (Ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready got %b expected 0", Ready); end
    if (Hex_out !== 16'h0000) begin miscompares++; $display("FAIL abort_hex got %h expected 0000", Hex_out); end
    if (Data_out !== 16'h0000) begin miscompares++; $display("FAIL abort_data_out got %h expected 0000", Data_out); end
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      if (c == 1) Reset = 1'b0;
      vectors++;
      if (Ready !== 1'b0) begin miscompares++; $display("FAIL abort_no_ready c%0d got %b expected 0", c, Ready); end
    end
    issue(1'b0, 20'h00020, 16'h0);
    repeat (2) @(posedge Clk);
    #1;
    vectors += 2;
    if (Ready !== 1'b1) begin miscompares++; $display("FAIL abort_rd_ready got %b expected 1", Ready); end
    if (Data_out !== 16'h0ABC) begin miscompares++; $display("FAIL abort_rd_data got %h expected 0abc", Data_out); end
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_mem_read();
    test_io();
    test_out_of_range();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
